timer_mm_driver: RTL and testbench
==================================

Name: timer_mm_driver

Overview:
- Avalon-MM initiator that programs, starts, services and stops the interval-timer slave: period_l/h, control, status and snap_l/h registers at word addresses 0-5.
- A client issues one command (period, mode, event count). The block runs the timer, services each IRQ by clearing status, and re-arms in one-shot mode.
- The block reports completion. On abort or watchdog expiry it captures the residual counter snapshot.
- Sits between a local sequencer and the timer's s1 slave port, replacing CPU software for timer housekeeping.

Parameters:
EVENT_W, 16, width of event count / done_events
WDOG_CYCLES, 32'd1_000_000, max clk cycles in WAIT_IRQ before watchdog abort; 0 disables

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_period  in  32  timer period value (load value)
cmd_continuous  in  1  1=continuous timer mode, 0=one-shot re-armed by driver
cmd_count  in  EVENT_W  timeouts to service before stop
abort  in  1  level; request early stop
m_address  out  3  timer word address
m_chipselect  out  1  bus cycle active
m_write_n  out  1  0=write, 1=read
m_writedata  out  16  write data
m_readdata  in  16  slave read data, fixed latency 1, no waitrequest
irq  in  1  timer interrupt
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
done_code  out  2  0=complete, 1=aborted, 2=watchdog
done_events  out  EVENT_W  timeouts serviced
snapshot  out  32  captured counter; valid with done when done_code!=0

Behaviour:
- Reset values: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, done=0, done_code=0, done_events=0, snapshot=0, busy=0, cmd_ready=1. Reset mid-sequence returns to IDLE immediately with no bus cycle.
- All bus outputs are registered. One bus access per state. Writes complete in 1 cycle.
- Reads: address presented in cycle N; m_readdata sampled at end of cycle N+1. Back-to-back reads are pipelined.
- Idle bus: chipselect=0, write_n=1.
- Accept: cmd_valid&&cmd_ready. Latch period, mode and count; clear event counter.
- cmd_count==0: go straight to DONE (code 0, events 0) with no bus traffic.
- States and writes:
  - IDLE.
  - WR_PL: addr2 = period[15:0].
  - WR_PH: addr3 = period[31:16].
  - WR_ST: addr0 = 0, clears stale timeout.
  - WR_CTL: addr1 = {0, start=1, cont, ito=1}, i.e. 0x7 continuous / 0x5 one-shot.
  - WAIT_IRQ.
  - CLR_ST: addr0 write.
  - GUARD: 1 idle cycle. irq drops one cycle after the status write; irq is not sampled in GUARD.
- After GUARD: events+1. If events==cmd_count, go to WR_STOP (code 0). Else if one-shot, go to WR_CTL (re-arm). Else go to WAIT_IRQ.
- Period registers are written before start because a period write stops the timer.
- WAIT_IRQ:
  - Watchdog counter cleared on entry.
  - abort=1 → WR_SNAP (code 1). abort has priority over a simultaneous irq.
  - Counter reaching WDOG_CYCLES → WR_SNAP (code 2).
  - Otherwise irq=1 → CLR_ST.
  - abort is ignored in other states until the next WAIT_IRQ.
- Abort path:
  - WR_SNAP: addr4 write, latches timer counter.
  - RD_SL: read addr4.
  - RD_SH: read addr5; capture snapshot[15:0].
  - RD_CAP: bus idle; capture snapshot[31:16].
  - WR_STOP, then WR_ST2: addr0 write, clears any pending timeout.
  - DONE.
- WR_STOP: addr1 = 0x0008 (stop, ito=0; irq masked).
- Normal completion: WR_STOP → DONE. snapshot is left unchanged.
- DONE: done=1 for one cycle with code and events valid, then IDLE. Outputs hold until the next DONE.
- Period 0 in continuous mode yields a single irq, so the watchdog terminates the command.
- Event counter never wraps; comparison is exact equality.

Decomposition:
- Package timer_mm_pkg:
  - Address constants TMR_STATUS=0, TMR_CONTROL=1, TMR_PERIOD_L=2, TMR_PERIOD_H=3, TMR_SNAP_L=4, TMR_SNAP_H=5.
  - Control bit positions ITO=0, CONT=1, START=2, STOP=3.
  - done_code enum.
  - State enum.
- Single module. No sub-module needed; the watchdog is an inline counter.

Test Plan:
- Reset mid-WR_CTL → next cycle chipselect=0, write_n=1, busy=0, cmd_ready=1.
- Command period=0x0001_0005, continuous=1, count=3 → bus writes in order:
  - addr2=0x0005, addr3=0x0001, addr0, addr1=0x0007.
  - Three irq services, each an addr0 write followed by 1 GUARD cycle.
  - addr1=0x0008, then done, code 0, events 3.
- One-shot, period=10, count=2 → addr1=0x0005 written twice (initial plus one re-arm), done events 2, no further bus traffic.
- Abort asserted in WAIT_IRQ with the slave counter at 0x0000_1234 → addr4 write, reads of 4 and 5, snapshot=0x0000_1234, then addr1=0x0008 and addr0 write. done code 1, events 0.
- WDOG_CYCLES=50, period=0 continuous, count=2 → one irq serviced, then watchdog fires 50 cycles after re-entering WAIT_IRQ. done code 2, events 1.
- cmd_count=0 → done pulses with code 0, events 0, zero chipselect cycles. abort and irq asserted on the same WAIT_IRQ cycle → abort path taken, code 1.

Source files
------------

// File: rtl/timer_mm_pkg.sv
// Shared definitions for the interval-timer housekeeping driver:
// slave register map, control bits, completion codes and FSM states.
package timer_mm_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] TMR_STATUS   = 3'd0;
    localparam logic [ADDR_W-1:0] TMR_CONTROL  = 3'd1;
    localparam logic [ADDR_W-1:0] TMR_PERIOD_L = 3'd2;
    localparam logic [ADDR_W-1:0] TMR_PERIOD_H = 3'd3;
    localparam logic [ADDR_W-1:0] TMR_SNAP_L   = 3'd4;
    localparam logic [ADDR_W-1:0] TMR_SNAP_H   = 3'd5;

    localparam int unsigned ITO   = 0;
    localparam int unsigned CONT  = 1;
    localparam int unsigned START = 2;
    localparam int unsigned STOP  = 3;

    typedef enum logic [1:0] {
        DONE_OK    = 2'd0,
        DONE_ABORT = 2'd1,
        DONE_WDOG  = 2'd2
    } done_code_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_PL    = 4'd1,
        ST_WR_PH    = 4'd2,
        ST_WR_ST    = 4'd3,
        ST_WR_CTL   = 4'd4,
        ST_WAIT_IRQ = 4'd5,
        ST_CLR_ST   = 4'd6,
        ST_GUARD    = 4'd7,
        ST_WR_SNAP  = 4'd8,
        ST_RD_SL    = 4'd9,
        ST_RD_SH    = 4'd10,
        ST_RD_CAP   = 4'd11,
        ST_WR_STOP  = 4'd12,
        ST_WR_ST2   = 4'd13,
        ST_DONE     = 4'd14
    } state_e;

    // Control register image from individual bit requests.
    function automatic logic [DATA_W-1:0] ctl_word(input logic start, input logic cont,
                                                   input logic ito, input logic stop);
        logic [DATA_W-1:0] w;
        w        = '0;
        w[ITO]   = ito;
        w[CONT]  = cont;
        w[START] = start;
        w[STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/timer_mm_driver.sv
// Avalon-MM initiator that programs, runs, services and stops the interval
// timer on behalf of a local sequencer, reporting a completion record.
module timer_mm_driver
    import timer_mm_pkg::*;
#(
    parameter int unsigned EVENT_W     = 16,
    parameter int unsigned WDOG_CYCLES = 32'd1_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_period,
    input  logic               cmd_continuous,
    input  logic [EVENT_W-1:0] cmd_count,
    input  logic               abort,
    output logic [2:0]         m_address,
    output logic               m_chipselect,
    output logic               m_write_n,
    output logic [15:0]        m_writedata,
    input  logic [15:0]        m_readdata,
    input  logic               irq,
    output logic               busy,
    output logic               done,
    output logic [1:0]         done_code,
    output logic [EVENT_W-1:0] done_events,
    output logic [31:0]        snapshot
);

    localparam int unsigned WDOG_W = 32;

    state_e               state_q, state_d;
    logic [31:0]          period_q, period_d;
    logic                 cont_q, cont_d;
    logic [EVENT_W-1:0]   count_q, count_d;
    logic [EVENT_W-1:0]   events_q, events_d;
    done_code_e           code_q, code_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;

    logic                 cs_d, wn_d, done_d, busy_d, ready_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [DATA_W-1:0]    wdata_d;
    logic [1:0]           done_code_d;
    logic [EVENT_W-1:0]   done_events_d;
    logic [31:0]          snapshot_d;
    logic                 wdog_hit;

    assign wdog_hit = (WDOG_CYCLES != 0) &&
                      ((wdog_q + WDOG_W'(1)) == WDOG_W'(WDOG_CYCLES));

    // State and all output registers; reset drops the bus immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            period_q     <= '0;
            cont_q       <= 1'b0;
            count_q      <= '0;
            events_q     <= '0;
            code_q       <= DONE_OK;
            wdog_q       <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= '0;
            m_writedata  <= '0;
            done         <= 1'b0;
            done_code    <= '0;
            done_events  <= '0;
            snapshot     <= '0;
            busy         <= 1'b0;
            cmd_ready    <= 1'b1;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            count_q      <= count_d;
            events_q     <= events_d;
            code_q       <= code_d;
            wdog_q       <= wdog_d;
            m_chipselect <= cs_d;
            m_write_n    <= wn_d;
            m_address    <= addr_d;
            m_writedata  <= wdata_d;
            done         <= done_d;
            done_code    <= done_code_d;
            done_events  <= done_events_d;
            snapshot     <= snapshot_d;
            busy         <= busy_d;
            cmd_ready    <= ready_d;
        end
    end

    // Next state, then the bus access belonging to that next state.
    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        cont_d        = cont_q;
        count_d       = count_q;
        events_d      = events_q;
        code_d        = code_q;
        wdog_d        = '0;
        snapshot_d    = snapshot;
        done_d        = 1'b0;
        done_code_d   = done_code;
        done_events_d = done_events;
        cs_d          = 1'b0;
        wn_d          = 1'b1;
        addr_d        = m_address;
        wdata_d       = m_writedata;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    period_d = cmd_period;
                    cont_d   = cmd_continuous;
                    count_d  = cmd_count;
                    events_d = '0;
                    code_d   = DONE_OK;
                    state_d  = (cmd_count == '0) ? ST_DONE : ST_WR_PL;
                end
            end
            ST_WR_PL:  state_d = ST_WR_PH;
            ST_WR_PH:  state_d = ST_WR_ST;
            ST_WR_ST:  state_d = ST_WR_CTL;
            ST_WR_CTL: state_d = ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (abort) begin
                    code_d  = DONE_ABORT;
                    state_d = ST_WR_SNAP;
                end else if (wdog_hit) begin
                    code_d  = DONE_WDOG;
                    state_d = ST_WR_SNAP;
                end else if (irq) begin
                    state_d = ST_CLR_ST;
                end
            end
            ST_CLR_ST: state_d = ST_GUARD;
            // irq is still falling here, so it is deliberately not looked at.
            ST_GUARD: begin
                events_d = events_q + EVENT_W'(1);
                if (events_d == count_q) begin
                    code_d  = DONE_OK;
                    state_d = ST_WR_STOP;
                end else if (!cont_q) begin
                    state_d = ST_WR_CTL;
                end else begin
                    state_d = ST_WAIT_IRQ;
                end
            end
            ST_WR_SNAP: state_d = ST_RD_SL;
            ST_RD_SL:   state_d = ST_RD_SH;
            ST_RD_SH: begin
                snapshot_d[15:0] = m_readdata;
                state_d          = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                snapshot_d[31:16] = m_readdata;
                state_d           = ST_WR_STOP;
            end
            ST_WR_STOP: state_d = (code_q == DONE_OK) ? ST_DONE : ST_WR_ST2;
            ST_WR_ST2:  state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_WR_PL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_PERIOD_L; wdata_d = period_d[15:0];
            end
            ST_WR_PH: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_PERIOD_H; wdata_d = period_q[31:16];
            end
            ST_WR_ST, ST_CLR_ST, ST_WR_ST2: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_STATUS; wdata_d = '0;
            end
            ST_WR_CTL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_CONTROL;
                wdata_d = ctl_word(1'b1, cont_q, 1'b1, 1'b0);
            end
            ST_WR_SNAP: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_SNAP_L; wdata_d = '0;
            end
            ST_RD_SL: begin
                cs_d = 1'b1; wn_d = 1'b1; addr_d = TMR_SNAP_L; wdata_d = '0;
            end
            ST_RD_SH: begin
                cs_d = 1'b1; wn_d = 1'b1; addr_d = TMR_SNAP_H; wdata_d = '0;
            end
            // Stop with ito cleared so the timer can no longer interrupt.
            ST_WR_STOP: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_CONTROL;
                wdata_d = ctl_word(1'b0, 1'b0, 1'b0, 1'b1);
            end
            default: begin
                cs_d = 1'b0; wn_d = 1'b1;
            end
        endcase

        if (state_d == ST_DONE) begin
            done_d        = 1'b1;
            done_code_d   = code_d;
            done_events_d = events_d;
        end
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

endmodule

// File: tb/tb_timer_mm_driver.sv
// Randomised scoreboard bench for timer_mm_driver with a behavioural timer
// slave and a transaction-level model of the expected bus/completion stream.
module tb_timer_mm_driver;

    localparam int unsigned EW = 16;
    localparam int unsigned WD = 50;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_period;
    logic          cmd_continuous;
    logic [EW-1:0] cmd_count;
    logic          abort;
    logic [2:0]    m_address;
    logic          m_chipselect;
    logic          m_write_n;
    logic [15:0]   m_writedata;
    logic [15:0]   m_readdata;
    logic          irq;
    logic          busy;
    logic          done;
    logic [1:0]    done_code;
    logic [EW-1:0] done_events;
    logic [31:0]   snapshot;

    timer_mm_driver #(.EVENT_W(EW), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .cmd_count(cmd_count),
        .abort(abort), .m_address(m_address), .m_chipselect(m_chipselect),
        .m_write_n(m_write_n), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .irq(irq), .busy(busy), .done(done), .done_code(done_code),
        .done_events(done_events), .snapshot(snapshot)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        bit          wr;
        logic [2:0]  addr;
        logic [15:0] data;
        int          gap;
        logic [1:0]  code;
        logic [15:0] ev;
        logic [31:0] snap;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_bus_cyc = 0;
    int          done_cnt = 0;
    logic [31:0] last_snap = 32'd0;

    // Termination scenario consumed by the slave model.
    int          t_kind = 0;
    int          t_idx = 0;
    bit          t_simul = 1'b0;
    logic [31:0] snap_src = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural timer slave: irq after a random delay per armed interval.
    logic [31:0] s_period, snap_reg;
    logic        s_cont, s_armed, s_clr_pend;
    int          s_cd, s_widx;
    always @(posedge clk) begin
        if (!reset_n) begin
            irq <= 1'b0; abort <= 1'b0; s_armed <= 1'b0; s_cd <= 0; s_widx <= -1;
            s_clr_pend <= 1'b0; m_readdata <= 16'h0; s_cont <= 1'b0;
            s_period <= 32'h0; snap_reg <= 32'h0;
        end else begin
            m_readdata <= 16'h0;
            if (m_chipselect && m_write_n)
                m_readdata <= (m_address == 3'd4) ? snap_reg[15:0] :
                              (m_address == 3'd5) ? snap_reg[31:16] : 16'h0;
            s_clr_pend <= m_chipselect && !m_write_n && (m_address == 3'd0);
            if (s_cd > 0) begin
                s_cd <= s_cd - 1;
                if (s_cd == 1) begin
                    if (t_kind == 1 && s_widx == t_idx) begin
                        abort <= 1'b1;
                        if (t_simul) irq <= 1'b1;
                    end else if (!(t_kind == 2 && s_widx == t_idx)) begin
                        irq <= 1'b1;
                    end
                end
            end
            if (s_clr_pend) begin
                irq <= 1'b0;
                if (s_armed && s_cont && s_period != 32'h0) begin
                    s_cd   <= int'($urandom_range(20, 2));
                    s_widx <= s_widx + 1;
                end
            end
            if (m_chipselect && !m_write_n) begin
                case (m_address)
                    3'd2: s_period[15:0]  <= m_writedata;
                    3'd3: s_period[31:16] <= m_writedata;
                    3'd4: snap_reg        <= snap_src;
                    3'd1: begin
                        if (m_writedata[2]) begin
                            s_armed <= 1'b1;
                            s_cont  <= m_writedata[1];
                            s_cd    <= int'($urandom_range(20, 2));
                            s_widx  <= s_widx + 1;
                        end
                        if (m_writedata[3]) begin
                            s_armed <= 1'b0;
                            s_cd    <= 0;
                        end
                    end
                    default: ;
                endcase
            end
            if (done) begin
                abort  <= 1'b0;
                s_widx <= -1;
            end
        end
    end

    // Monitor: every bus cycle and every done pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (m_chipselect) begin
                if (exp_q.size() == 0) begin
                    chk("bus_unexpected_addr", {29'd0, m_address}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("bus_order_not_done", 32'(e.is_done), 32'd0);
                    chk("bus_is_write", 32'(!m_write_n), 32'(e.wr));
                    chk("bus_addr", 32'(m_address), 32'(e.addr));
                    if (e.wr) chk("bus_wdata", 32'(m_writedata), 32'(e.data));
                    if (e.gap >= 0) chk("bus_gap", 32'(cyc - last_bus_cyc), 32'(e.gap));
                end
                last_bus_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("done_busy", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'(done_code), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_order", 32'(e.is_done), 32'd1);
                    chk("done_code", 32'(done_code), 32'(e.code));
                    chk("done_events", 32'(done_events), 32'(e.ev));
                    chk("done_snapshot", snapshot, e.snap);
                    if (e.gap >= 0) chk("done_gap", 32'(cyc - last_bus_cyc), 32'(e.gap));
                end
            end
        end
    end

    function automatic exp_t bus_item(input bit wr, input logic [2:0] a,
                                      input logic [15:0] d, input int gap);
        exp_t e;
        e = '{is_done: 1'b0, wr: wr, addr: a, data: d, gap: gap,
              code: 2'd0, ev: 16'd0, snap: 32'd0};
        return e;
    endfunction

    function automatic exp_t done_item(input logic [1:0] c, input int ev,
                                       input logic [31:0] s, input int gap);
        exp_t e;
        e = '{is_done: 1'b1, wr: 1'b0, addr: 3'd0, data: 16'd0, gap: gap,
              code: c, ev: 16'(ev), snap: s};
        return e;
    endfunction

    // Reference: expected transaction stream for one command and its outcome.
    task automatic build_expected(input logic [31:0] p, input bit cont, input int count,
                                  input int kind, input int idx, input logic [31:0] sv);
        logic [15:0] ctl;
        bit          prev_clr;
        int          code;
        ctl      = cont ? 16'h0007 : 16'h0005;
        prev_clr = 1'b0;
        if (count == 0) begin
            exp_q.push_back(done_item(2'd0, 0, last_snap, -1));
            return;
        end
        exp_q.push_back(bus_item(1'b1, 3'd2, p[15:0], -1));
        exp_q.push_back(bus_item(1'b1, 3'd3, p[31:16], 1));
        exp_q.push_back(bus_item(1'b1, 3'd0, 16'h0, 1));
        exp_q.push_back(bus_item(1'b1, 3'd1, ctl, 1));
        for (int i = 0; i < count; i++) begin
            code = 0;
            if (kind != 0 && i == idx) code = kind;
            else if (cont && p == 32'h0 && i >= 1) code = 2;
            if (code != 0) begin
                exp_q.push_back(bus_item(1'b1, 3'd4, 16'h0,
                                         (code == 2) ? (prev_clr ? WD + 2 : WD + 1) : -1));
                exp_q.push_back(bus_item(1'b0, 3'd4, 16'h0, 1));
                exp_q.push_back(bus_item(1'b0, 3'd5, 16'h0, 1));
                exp_q.push_back(bus_item(1'b1, 3'd1, 16'h0008, 2));
                exp_q.push_back(bus_item(1'b1, 3'd0, 16'h0, 1));
                exp_q.push_back(done_item(2'(code), i, sv, 1));
                last_snap = sv;
                return;
            end
            exp_q.push_back(bus_item(1'b1, 3'd0, 16'h0, -1));
            prev_clr = 1'b1;
            if (i + 1 == count) begin
                exp_q.push_back(bus_item(1'b1, 3'd1, 16'h0008, 2));
                exp_q.push_back(done_item(2'd0, count, last_snap, 1));
                return;
            end
            if (!cont) begin
                exp_q.push_back(bus_item(1'b1, 3'd1, ctl, 2));
                prev_clr = 1'b0;
            end
        end
    endtask

    task automatic run_cmd(input logic [31:0] p, input bit cont, input int count,
                           input int kind, input int idx, input bit simul,
                           input logic [31:0] sv);
        int d0;
        int n;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        t_kind = kind; t_idx = idx; t_simul = simul; snap_src = sv;
        build_expected(p, cont, count, kind, idx, sv);
        d0 = done_cnt;
        cmd_valid = 1'b1; cmd_period = p; cmd_continuous = cont; cmd_count = EW'(count);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=no_done required=done period=%h count=%0d", p, count);
            reset_n = 1'b0;
            exp_q.delete();
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            last_snap = 32'd0;
        end
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        logic [31:0] p;
        bit c;
        int cnt, kind, idx;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_period = '0; cmd_continuous = 1'b0;
        cmd_count = '0;
        repeat (3) @(negedge clk);
        chk("rst_chipselect", 32'(m_chipselect), 32'd0);
        chk("rst_write_n", 32'(m_write_n), 32'd1);
        chk("rst_address", 32'(m_address), 32'd0);
        chk("rst_writedata", 32'(m_writedata), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_code", 32'(done_code), 32'd0);
        chk("rst_done_events", 32'(done_events), 32'd0);
        chk("rst_snapshot", snapshot, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset landing while the control write is on the bus.
        t_kind = 0;
        build_expected(32'h0000_0100, 1'b1, 2, 0, 0, 32'h0);
        cmd_valid = 1'b1; cmd_period = 32'h0000_0100; cmd_continuous = 1'b1; cmd_count = 16'd2;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!(m_chipselect && !m_write_n && m_address == 3'd1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midctl_reached", 32'(m_address), 32'd1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_chipselect", 32'(m_chipselect), 32'd0);
        chk("midrst_write_n", 32'(m_write_n), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        chk("midrst_hold_chipselect", 32'(m_chipselect), 32'd0);
        reset_n = 1'b1;
        last_snap = 32'd0;
        repeat (2) @(negedge clk);

        run_cmd(32'h0001_0005, 1'b1, 3, 0, 0, 1'b0, 32'h0);
        run_cmd(32'd10,        1'b0, 2, 0, 0, 1'b0, 32'h0);
        run_cmd(32'd500,       1'b1, 5, 1, 0, 1'b0, 32'h0000_1234);
        run_cmd(32'd0,         1'b1, 2, 0, 0, 1'b0, 32'hDEAD_0001);
        run_cmd(32'd77,        1'b0, 0, 0, 0, 1'b0, 32'h0);
        run_cmd(32'd300,       1'b1, 4, 1, 1, 1'b1, 32'hCAFE_5A5A);
        run_cmd(32'd40,        1'b0, 3, 2, 2, 1'b0, 32'h0BAD_F00D);

        for (int r = 0; r < 24; r++) begin
            p    = $urandom;
            if ($urandom_range(3, 0) == 0) p = 32'h0;
            c    = 1'($urandom_range(1, 0));
            cnt  = int'($urandom_range(5, 0));
            kind = int'($urandom_range(2, 0));
            idx  = (cnt > 0) ? int'($urandom_range(cnt - 1, 0)) : 0;
            if (cnt == 0 || (c && p == 32'h0)) kind = 0;
            run_cmd(p, c, cnt, kind, idx, 1'($urandom_range(1, 0)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
